param_updown_counter: RTL

Parametrised successor of the 4-bit serial-carry T-counter. It provides an N-bit modulo-M synchronous counter with count enable, up/down direction, synchronous parallel load, and carry/borrow in/out for cascading several instances into multi-digit counters (e.g. BCD chains). It is the counting primitive for timers and dividers in the datapath labs. All state changes occur on the falling edge of Ck, consistent with the existing counter and flip-flop blocks.

---
 rtl/param_updown_counter.sv | 107 ++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// param_updown_counter: N-bit modulo-M synchronous up/down counter with
// parallel load and carry/borrow cascade; state changes on the falling edge of Ck.
module param_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 0
) (
    input  logic             Ck,
    input  logic             reset,
    input  logic             T,
    input  logic             Cin,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Cout,
    output logic             wrap,
    output logic             lderr
);

    localparam int unsigned MOD_EFF = (MODULUS == 0) ? (32'd1 << WIDTH) : MODULUS;
    localparam int unsigned TOP_I   = MOD_EFF - 1;

    // Modulus and terminal count held at WIDTH+1 bits so that M == 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD = MOD_EFF[WIDTH:0];
    localparam logic [WIDTH:0] TOP = TOP_I[WIDTH:0];
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    generate
        if (WIDTH < 1 || WIDTH > 16 || MOD_EFF < 2 || MOD_EFF > (32'd1 << WIDTH)) begin : g_bad_param
            $fatal(1, "param_updown_counter: illegal WIDTH/MODULUS (WIDTH=%0d MODULUS=%0d)",
                   WIDTH, MODULUS);
        end
    endgenerate

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             lderr_q, lderr_d;

    logic [WIDTH:0]   cur;
    logic [WIDTH:0]   q_up;
    logic [WIDTH:0]   q_dn;
    logic             en;
    logic             at_top;
    logic             at_zero;

    assign cur  = {1'b0, q_q};
    assign q_up = cur + ONE;
    assign q_dn = cur - ONE;
    assign en   = T & Cin;

    // Terminal detection from the widened sum/difference: reaching M going up,
    // or borrowing into the extra bit going down.
    assign at_top  = (q_up == MOD);
    assign at_zero = q_dn[WIDTH];

    // Cascade carry/borrow is combinational so the next stage counts on the same edge.
    assign Cout = en & (up ? at_top : at_zero);

    // Next-state selection: load over count over hold (reset handled in the register).
    always_comb begin
        q_d     = q_q;
        wrap_d  = 1'b0;
        lderr_d = 1'b0;
        if (load) begin
            if ({1'b0, D} > TOP) begin
                q_d     = TOP[WIDTH-1:0];
                lderr_d = 1'b1;
            end else begin
                q_d = D;
            end
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_up[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    q_d    = TOP[WIDTH-1:0];
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_dn[WIDTH-1:0];
                end
            end
        end
    end

    // State register on the falling edge with synchronous reset.
    always_ff @(negedge Ck) begin
        if (reset) begin
            q_q     <= '0;
            wrap_q  <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            lderr_q <= lderr_d;
        end
    end

    assign Q     = q_q;
    assign wrap  = wrap_q;
    assign lderr = lderr_q;

endmodule
